// File: rtl/usb_rx_deserializer.sv
// USB receive front end: SYNC hunt, NRZI decode, bit-unstuffing and LSB-first
// byte assembly, with EOP detection and error/abort recovery.
module usb_rx_deserializer #(
  parameter int MAX_BYTES      = 1027,
  parameter int SYNC_MIN_ZEROS = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       usb_full_speed,
  input  logic       bit_strobe,
  input  logic [1:0] d_i,
  output logic       rx_active,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_eop,
  output logic       rx_error
);

  localparam int BCW = $clog2(MAX_BYTES + 1);
  localparam logic [BCW-1:0] MAX_CNT  = BCW'(MAX_BYTES);
  localparam logic [2:0]     SYNC_MIN = 3'(SYNC_MIN_ZEROS);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_EOP, S_ABORT} state_t;

  state_t         r_state, w_state_next;
  logic           r_prev_k, w_prev_k_next;
  logic [2:0]     r_zeros, w_zeros_next;
  logic [2:0]     r_ones, w_ones_next;
  logic [2:0]     r_bit_cnt, w_bit_cnt_next;
  logic [BCW-1:0] r_byte_cnt, w_byte_cnt_next;
  logic [7:0]     r_shreg, w_shreg_next;
  logic [7:0]     r_data, w_data_next;
  logic           r_valid, w_valid_next;
  logic           r_eop, w_eop_next;
  logic           r_error, w_error_next;
  logic           r_abort_se0, w_abort_se0_next;
  logic [2:0]     r_j_cnt, w_j_cnt_next;

  logic       w_se0, w_se1, w_j, w_k, w_bit;
  logic [7:0] w_byte;

  assign w_se0  = (d_i == 2'b00);
  assign w_se1  = (d_i == 2'b11);
  assign w_j    = (d_i == (usb_full_speed ? 2'b10 : 2'b01));
  assign w_k    = !w_se0 && !w_se1 && !w_j;
  // Previous level is kept as a J/K class so it stays valid across speeds.
  assign w_bit  = (w_k == r_prev_k);
  assign w_byte = {w_bit, r_shreg[7:1]};

  always_comb begin
    w_state_next     = r_state;
    w_prev_k_next    = r_prev_k;
    w_zeros_next     = r_zeros;
    w_ones_next      = r_ones;
    w_bit_cnt_next   = r_bit_cnt;
    w_byte_cnt_next  = r_byte_cnt;
    w_shreg_next     = r_shreg;
    w_data_next      = r_data;
    w_valid_next     = 1'b0;
    w_eop_next       = 1'b0;
    w_error_next     = 1'b0;
    w_abort_se0_next = r_abort_se0;
    w_j_cnt_next     = r_j_cnt;

    if (r_state != S_ABORT) begin
      w_abort_se0_next = 1'b0;
      w_j_cnt_next     = 3'd0;
    end

    if (bit_strobe) begin
      if (w_j || w_k) w_prev_k_next = w_k;

      case (r_state)
        S_IDLE: begin
          if (w_se0 || w_se1) begin
            w_zeros_next = 3'd0;
          end else if (w_bit) begin
            if (r_zeros >= SYNC_MIN) begin
              w_state_next    = S_DATA;
              w_bit_cnt_next  = 3'd0;
              w_byte_cnt_next = '0;
              w_ones_next     = 3'd0;
            end
            w_zeros_next = 3'd0;
          end else if (r_zeros != 3'd7) begin
            w_zeros_next = r_zeros + 3'd1;
          end
        end

        S_DATA: begin
          if (w_se1) begin
            w_error_next = 1'b1;
            w_state_next = S_ABORT;
          end else if (w_se0) begin
            // A pending stuff bit is fine here; only a partial byte is an error.
            w_error_next = (r_bit_cnt != 3'd0);
            w_state_next = S_EOP;
          end else if (r_ones == 3'd6) begin
            if (w_bit) begin
              w_error_next = 1'b1;
              w_state_next = S_ABORT;
            end else begin
              w_ones_next = 3'd0;
            end
          end else begin
            w_shreg_next   = w_byte;
            w_bit_cnt_next = r_bit_cnt + 3'd1;
            w_ones_next    = w_bit ? r_ones + 3'd1 : 3'd0;
            if (r_bit_cnt == 3'd7) begin
              if (r_byte_cnt == MAX_CNT) begin
                w_error_next = 1'b1;
                w_state_next = S_ABORT;
              end else begin
                w_data_next     = w_byte;
                w_valid_next    = 1'b1;
                w_byte_cnt_next = r_byte_cnt + 1'b1;
              end
            end
          end
        end

        S_EOP: begin
          if (w_j) begin
            w_eop_next   = 1'b1;
            w_zeros_next = 3'd0;
            w_state_next = S_IDLE;
          end else if (!w_se0) begin
            w_error_next = 1'b1;
            w_state_next = S_ABORT;
          end
        end

        S_ABORT: begin
          // Recover on SE0-then-J or on a long run of idle J.
          if (w_se0) begin
            w_abort_se0_next = 1'b1;
            w_j_cnt_next     = 3'd0;
          end else if (w_j) begin
            if (r_abort_se0 || r_j_cnt == 3'd7) begin
              w_zeros_next = 3'd0;
              w_state_next = S_IDLE;
            end else begin
              w_j_cnt_next = r_j_cnt + 3'd1;
            end
          end else begin
            w_abort_se0_next = 1'b0;
            w_j_cnt_next     = 3'd0;
          end
        end

        default: w_state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_prev_k    <= 1'b0;
      r_zeros     <= 3'd0;
      r_ones      <= 3'd0;
      r_bit_cnt   <= 3'd0;
      r_byte_cnt  <= '0;
      r_shreg     <= 8'd0;
      r_data      <= 8'd0;
      r_valid     <= 1'b0;
      r_eop       <= 1'b0;
      r_error     <= 1'b0;
      r_abort_se0 <= 1'b0;
      r_j_cnt     <= 3'd0;
    end else begin
      r_state     <= w_state_next;
      r_prev_k    <= w_prev_k_next;
      r_zeros     <= w_zeros_next;
      r_ones      <= w_ones_next;
      r_bit_cnt   <= w_bit_cnt_next;
      r_byte_cnt  <= w_byte_cnt_next;
      r_shreg     <= w_shreg_next;
      r_data      <= w_data_next;
      r_valid     <= w_valid_next;
      r_eop       <= w_eop_next;
      r_error     <= w_error_next;
      r_abort_se0 <= w_abort_se0_next;
      r_j_cnt     <= w_j_cnt_next;
    end
  end

  assign rx_active = (r_state != S_IDLE);
  assign rx_data   = r_data;
  assign rx_valid  = r_valid;
  assign rx_eop    = r_eop;
  assign rx_error  = r_error;

endmodule

// File: tb/tb_usb_rx_deserializer.sv
// Directed bench for usb_rx_deserializer: a small NRZI/bit-stuff encoder drives
// packets, a negedge monitor counts output pulses, and expectations are hand-derived.
module tb_usb_rx_deserializer;

  logic       clk = 1'b0;
  logic       reset;
  logic       usb_full_speed;
  logic       bit_strobe;
  logic [1:0] d_i;
  logic       rx_active;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_eop;
  logic       rx_error;

  usb_rx_deserializer dut (
    .clk            (clk),
    .reset          (reset),
    .usb_full_speed (usb_full_speed),
    .bit_strobe     (bit_strobe),
    .d_i            (d_i),
    .rx_active      (rx_active),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .rx_eop         (rx_eop),
    .rx_error       (rx_error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Pulse monitor
  int         n_valid = 0;
  int         n_eop   = 0;
  int         n_err   = 0;
  int         n_act   = 0;
  logic [7:0] rx_q[$];

  always @(negedge clk) begin
    if (!reset) begin
      if (rx_valid) begin
        n_valid <= n_valid + 1;
        rx_q.push_back(rx_data);
      end
      if (rx_eop)    n_eop <= n_eop + 1;
      if (rx_error)  n_err <= n_err + 1;
      if (rx_active) n_act <= n_act + 1;
    end
  end

  int   b_valid, b_eop, b_err, b_act, b_q;
  bit   tb_k;
  int   ones;
  logic obs_valid, obs_eop, obs_err;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] lvl(input bit k);
    return (k ^ usb_full_speed) ? 2'b10 : 2'b01;
  endfunction

  // One bit period: strobe for one clk, then three idle clks.
  task automatic drive(input logic [1:0] v);
    @(negedge clk);
    d_i        = v;
    bit_strobe = 1'b1;
    @(negedge clk);
    bit_strobe = 1'b0;
    obs_valid  = rx_valid;
    obs_eop    = rx_eop;
    obs_err    = rx_error;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic send_k(input bit k);
    tb_k = k;
    drive(lvl(k));
  endtask

  task automatic send_nrzi(input bit b);
    if (!b) tb_k = !tb_k;
    drive(lvl(tb_k));
  endtask

  task automatic send_data_bit(input bit b, input bit bad_stuff);
    send_nrzi(b);
    ones = b ? ones + 1 : 0;
    if (ones == 6) begin
      send_nrzi(bad_stuff);
      ones = 0;
    end
  endtask

  task automatic send_byte(input logic [7:0] v, input bit bad_stuff);
    for (int i = 0; i < 8; i++) send_data_bit(v[i], bad_stuff);
  endtask

  task automatic send_sync();
    send_k(1); send_k(0); send_k(1); send_k(0);
    send_k(1); send_k(0); send_k(1); send_k(1);
    ones = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send_k(0);
  endtask

  task automatic snap();
    b_valid = n_valid;
    b_eop   = n_eop;
    b_err   = n_err;
    b_act   = n_act;
    b_q     = rx_q.size();
  endtask

  task automatic ack_packet(input string tag);
    snap();
    idle(4);
    send_sync();
    check_eq({tag, "_active"}, 32'(rx_active), 32'd1);
    send_byte(8'hD2, 1'b0);
    check_eq({tag, "_valid_lat"}, 32'(obs_valid), 32'd1);
    check_eq({tag, "_data"}, 32'(rx_data), 32'hD2);
    drive(2'b00);
    drive(2'b00);
    send_k(0);
    check_eq({tag, "_eop_lat"}, 32'(obs_eop), 32'd1);
    check_eq({tag, "_active_end"}, 32'(rx_active), 32'd0);
    check_eq({tag, "_nvalid"}, 32'(n_valid - b_valid), 32'd1);
    check_eq({tag, "_neop"}, 32'(n_eop - b_eop), 32'd1);
    check_eq({tag, "_nerr"}, 32'(n_err - b_err), 32'd0);
    $display("pkt %s: bytes=%0d eop=%0d err=%0d", tag, n_valid - b_valid, n_eop - b_eop, n_err - b_err);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset          = 1'b1;
    usb_full_speed = 1'b1;
    bit_strobe     = 1'b0;
    d_i            = 2'b10;
    tb_k           = 1'b0;
    ones           = 0;
    repeat (3) @(negedge clk);
    check_eq("rst_active", 32'(rx_active), 32'd0);
    check_eq("rst_valid",  32'(rx_valid),  32'd0);
    check_eq("rst_eop",    32'(rx_eop),    32'd0);
    check_eq("rst_error",  32'(rx_error),  32'd0);
    check_eq("rst_data",   32'(rx_data),   32'd0);
    reset = 1'b0;

    // Full-speed and low-speed ACK handshake
    ack_packet("ack_fs");
    usb_full_speed = 1'b0;
    ack_packet("ack_ls");
    usb_full_speed = 1'b1;

    // 0xFF forces a stuffed zero, then 0x00
    snap();
    idle(4);
    send_sync();
    send_byte(8'hFF, 1'b0);
    send_byte(8'h00, 1'b0);
    drive(2'b00); drive(2'b00); send_k(0);
    check_eq("stuff_nvalid", 32'(n_valid - b_valid), 32'd2);
    check_eq("stuff_byte0", 32'(rx_q[b_q]), 32'hFF);
    check_eq("stuff_byte1", 32'(rx_q[b_q + 1]), 32'h00);
    check_eq("stuff_nerr", 32'(n_err - b_err), 32'd0);
    check_eq("stuff_neop", 32'(n_eop - b_eop), 32'd1);
    $display("pkt stuff_ok: bytes=%0d eop=%0d err=%0d", n_valid - b_valid, n_eop - b_eop, n_err - b_err);

    // Stuffed bit replaced by 1: stuff error, abort, no EOP
    snap();
    idle(4);
    send_sync();
    send_byte(8'hFF, 1'b1);
    check_eq("badstuff_nerr", 32'(n_err - b_err), 32'd1);
    check_eq("badstuff_active", 32'(rx_active), 32'd1);
    drive(2'b00); send_k(0);
    check_eq("badstuff_exit", 32'(rx_active), 32'd0);
    check_eq("badstuff_neop", 32'(n_eop - b_eop), 32'd0);
    check_eq("badstuff_nvalid", 32'(n_valid - b_valid), 32'd0);
    $display("pkt bad_stuff: bytes=%0d eop=%0d err=%0d", n_valid - b_valid, n_eop - b_eop, n_err - b_err);

    // SE0 after 12 data bits: partial byte dropped with error, EOP still reported
    snap();
    idle(4);
    send_sync();
    send_byte(8'h3C, 1'b0);
    send_data_bit(1, 0); send_data_bit(0, 0); send_data_bit(1, 0); send_data_bit(0, 0);
    drive(2'b00);
    check_eq("partial_err_lat", 32'(obs_err), 32'd1);
    drive(2'b00);
    send_k(0);
    check_eq("partial_eop_lat", 32'(obs_eop), 32'd1);
    check_eq("partial_nvalid", 32'(n_valid - b_valid), 32'd1);
    check_eq("partial_data", 32'(rx_q[b_q]), 32'h3C);
    check_eq("partial_nerr", 32'(n_err - b_err), 32'd1);
    check_eq("partial_neop", 32'(n_eop - b_eop), 32'd1);
    $display("pkt partial: bytes=%0d eop=%0d err=%0d", n_valid - b_valid, n_eop - b_eop, n_err - b_err);

    // Asynchronous reset between bits 3 and 4 of byte 2
    idle(4);
    send_sync();
    send_byte(8'hA5, 1'b0);
    send_data_bit(1, 0); send_data_bit(1, 0); send_data_bit(1, 0);
    check_eq("midrst_pre_data", 32'(rx_data), 32'hA5);
    #2 reset = 1'b1;
    #1;
    check_eq("midrst_active", 32'(rx_active), 32'd0);
    check_eq("midrst_data", 32'(rx_data), 32'd0);
    check_eq("midrst_valid", 32'(rx_valid), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    tb_k  = 1'b0;
    ones  = 0;
    ack_packet("after_reset");

    // Truncated SYNC (KJKK) followed by data-like bits: never leaves IDLE
    snap();
    idle(4);
    send_k(1); send_k(0); send_k(1); send_k(1);
    for (int i = 0; i < 8; i++) send_nrzi(i[0]);
    idle(4);
    check_eq("trunc_active_cycles", 32'(n_act - b_act), 32'd0);
    check_eq("trunc_nvalid", 32'(n_valid - b_valid), 32'd0);
    $display("pkt trunc_sync: active_cycles=%0d", n_act - b_act);

    // Babble: MAX_BYTES+1 bytes without EOP
    snap();
    idle(4);
    send_sync();
    for (int i = 0; i < 1027; i++) send_byte(8'h00, 1'b0);
    check_eq("babble_nvalid", 32'(n_valid - b_valid), 32'd1027);
    check_eq("babble_noerr_yet", 32'(n_err - b_err), 32'd0);
    send_byte(8'h00, 1'b0);
    check_eq("babble_err_lat", 32'(obs_err), 32'd1);
    check_eq("babble_nerr", 32'(n_err - b_err), 32'd1);
    check_eq("babble_nvalid_end", 32'(n_valid - b_valid), 32'd1027);
    drive(2'b00); send_k(0);
    check_eq("babble_exit", 32'(rx_active), 32'd0);
    check_eq("babble_neop", 32'(n_eop - b_eop), 32'd0);
    $display("pkt babble: bytes=%0d eop=%0d err=%0d", n_valid - b_valid, n_eop - b_eop, n_err - b_err);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
